// File: rtl/reg_file_scoreboard.sv
// Register file with hard-wired zero register, optional writeback bypass and a
// per-register write-pending scoreboard used by decode for hazard detection.
module reg_file_scoreboard #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned NREGS = 8,
  parameter int unsigned BYPASS = 1,
  localparam int unsigned AW = $clog2(NREGS)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [AW-1:0]    Read1,
  input  logic [AW-1:0]    Read2,
  output logic [WIDTH-1:0] Data1,
  output logic [WIDTH-1:0] Data2,
  input  logic             RegWrite,
  input  logic [AW-1:0]    EscReg,
  input  logic [WIDTH-1:0] WriteData,
  input  logic             Reserve,
  input  logic [AW-1:0]    ResReg,
  output logic             Busy1,
  output logic             Busy2,
  output logic             Hazard,
  output logic [AW:0]      PendCount,
  output logic             ResErr
);

  logic [WIDTH-1:0] rf_q [NREGS];
  logic [NREGS-1:0] pend_q, pend_d;
  logic [AW:0]      pend_count_q, pend_count_d;
  logic             res_err_q, res_err_d;

  logic wr_en, res_en, same_reg, cnt_inc, cnt_dec;

  assign wr_en    = RegWrite && (EscReg != '0);
  assign res_en   = Reserve && (ResReg != '0);
  assign same_reg = wr_en && res_en && (EscReg == ResReg);

  always_comb begin
    pend_d       = pend_q;
    cnt_inc      = 1'b0;
    cnt_dec      = 1'b0;
    res_err_d    = res_err_q;
    if (wr_en) begin
      pend_d[EscReg] = 1'b0;
    end
    // Reserve is applied after the write so it wins on a shared index.
    if (res_en) begin
      pend_d[ResReg] = 1'b1;
    end
    cnt_inc = res_en && !pend_q[ResReg];
    cnt_dec = wr_en && pend_q[EscReg] && !same_reg;
    if (res_en && pend_q[ResReg] && !same_reg) begin
      res_err_d = 1'b1;
    end
    pend_count_d = pend_count_q + (AW + 1)'(cnt_inc) - (AW + 1)'(cnt_dec);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < int'(NREGS); i++) begin
        rf_q[i] <= '0;
      end
      pend_q       <= '0;
      pend_count_q <= '0;
      res_err_q    <= 1'b0;
    end else begin
      if (wr_en) begin
        rf_q[EscReg] <= WriteData;
      end
      pend_q       <= pend_d;
      pend_count_q <= pend_count_d;
      res_err_q    <= res_err_d;
    end
  end

  always_comb begin
    Data1 = rf_q[Read1];
    Busy1 = pend_q[Read1];
    Data2 = rf_q[Read2];
    Busy2 = pend_q[Read2];
    if (BYPASS != 0 && wr_en && EscReg == Read1) begin
      Data1 = WriteData;
      Busy1 = 1'b0;
    end
    if (BYPASS != 0 && wr_en && EscReg == Read2) begin
      Data2 = WriteData;
      Busy2 = 1'b0;
    end
    if (Read1 == '0) begin
      Data1 = '0;
      Busy1 = 1'b0;
    end
    if (Read2 == '0) begin
      Data2 = '0;
      Busy2 = 1'b0;
    end
  end

  assign Hazard    = Busy1 | Busy2;
  assign PendCount = pend_count_q;
  assign ResErr    = res_err_q;

endmodule

// File: tb/tb_reg_file_scoreboard.sv
// Directed bench: a BYPASS=1 and a BYPASS=0 instance share all inputs.
module tb_reg_file_scoreboard;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [2:0] Read1 = '0, Read2 = '0, EscReg = '0, ResReg = '0;
  logic       RegWrite = 1'b0, Reserve = 1'b0;
  logic [7:0] WriteData = '0;

  logic [7:0] a_d1, a_d2, b_d1, b_d2;
  logic       a_b1, a_b2, a_hz, a_err, b_b1, b_b2, b_hz, b_err;
  logic [3:0] a_cnt, b_cnt;

  int vectors = 0;
  int miscompares = 0;

  always #5 clock = ~clock;

  reg_file_scoreboard #(.WIDTH(8), .NREGS(8), .BYPASS(1)) u_dut (
    .clock(clock), .reset(reset), .Read1(Read1), .Read2(Read2), .Data1(a_d1), .Data2(a_d2),
    .RegWrite(RegWrite), .EscReg(EscReg), .WriteData(WriteData), .Reserve(Reserve),
    .ResReg(ResReg), .Busy1(a_b1), .Busy2(a_b2), .Hazard(a_hz), .PendCount(a_cnt),
    .ResErr(a_err)
  );

  reg_file_scoreboard #(.WIDTH(8), .NREGS(8), .BYPASS(0)) u_dut_nobyp (
    .clock(clock), .reset(reset), .Read1(Read1), .Read2(Read2), .Data1(b_d1), .Data2(b_d2),
    .RegWrite(RegWrite), .EscReg(EscReg), .WriteData(WriteData), .Reserve(Reserve),
    .ResReg(ResReg), .Busy1(b_b1), .Busy2(b_b2), .Hazard(b_hz), .PendCount(b_cnt),
    .ResErr(b_err)
  );

  // Advance one edge, then drop the one-shot controls.
  task automatic tick();
    @(posedge clock);
    #1;
    RegWrite = 1'b0;
    Reserve  = 1'b0;
    reset    = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    for (int i = 0; i < 8; i++) begin
      Read1 = 3'(i);
      Read2 = 3'(7 - i);
      #1;
      vectors++;
      if ({a_d1, a_d2, b_d1, b_d2} !== 32'h0 ||
          {a_b1, a_b2, a_hz, a_err, b_b1, b_b2, b_hz, b_err} !== 8'h0 ||
          a_cnt !== 4'd0 || b_cnt !== 4'd0) begin
        miscompares++;
        $display("FAIL reset_idle r%0d: data %h %h %h %h flags %b%b%b%b cnt %0d/%0d, want all 0",
                 i, a_d1, a_d2, b_d1, b_d2, a_b1, a_b2, a_hz, a_err, a_cnt, b_cnt);
      end
    end
  endtask

  task automatic test_write_read();
    RegWrite = 1'b1; EscReg = 3'd3; WriteData = 8'hA5;
    tick();
    Read1 = 3'd3;
    #1;
    vectors++;
    if (a_d1 !== 8'hA5 || b_d1 !== 8'hA5) begin
      miscompares++;
      $display("FAIL write_r3: got %h/%h want a5", a_d1, b_d1);
    end
    RegWrite = 1'b1; EscReg = 3'd0; WriteData = 8'hFF;
    Reserve = 1'b1; ResReg = 3'd0;
    tick();
    Read1 = 3'd0;
    #1;
    vectors++;
    if (a_d1 !== 8'h00 || a_b1 !== 1'b0 || a_cnt !== 4'd0 || a_err !== 1'b0) begin
      miscompares++;
      $display("FAIL write_r0: data %h busy %b cnt %0d err %b want 00 0 0 0",
               a_d1, a_b1, a_cnt, a_err);
    end
  endtask

  task automatic test_bypass();
    Reserve = 1'b1; ResReg = 3'd5;
    tick();
    RegWrite = 1'b1; EscReg = 3'd5; WriteData = 8'h3C; Read1 = 3'd5; Read2 = 3'd0;
    #1;
    vectors++;
    if (a_d1 !== 8'h3C || a_b1 !== 1'b0 || a_hz !== 1'b0) begin
      miscompares++;
      $display("FAIL bypass_on: data %h busy %b hz %b want 3c 0 0", a_d1, a_b1, a_hz);
    end
    vectors++;
    if (b_d1 !== 8'h00 || b_b1 !== 1'b1 || b_hz !== 1'b1) begin
      miscompares++;
      $display("FAIL bypass_off: data %h busy %b hz %b want 00 1 1", b_d1, b_b1, b_hz);
    end
    tick();
    vectors++;
    if (a_cnt !== 4'd0 || b_cnt !== 4'd0 || a_d1 !== 8'h3C || b_d1 !== 8'h3C) begin
      miscompares++;
      $display("FAIL bypass_after: cnt %0d/%0d data %h/%h want 0/0 3c/3c",
               a_cnt, b_cnt, a_d1, b_d1);
    end
  endtask

  task automatic test_reserve_release();
    Reserve = 1'b1; ResReg = 3'd2;
    tick();
    Read1 = 3'd2; Read2 = 3'd3;
    #1;
    vectors++;
    if (a_b1 !== 1'b1 || a_b2 !== 1'b0 || a_hz !== 1'b1 || a_cnt !== 4'd1) begin
      miscompares++;
      $display("FAIL reserve_r2: busy %b%b hz %b cnt %0d want 10 1 1", a_b1, a_b2, a_hz, a_cnt);
    end
    RegWrite = 1'b1; EscReg = 3'd2; WriteData = 8'h11;
    tick();
    vectors++;
    if (a_b1 !== 1'b0 || a_hz !== 1'b0 || a_cnt !== 4'd0 || a_d1 !== 8'h11 ||
        b_b1 !== 1'b0 || b_d1 !== 8'h11) begin
      miscompares++;
      $display("FAIL release_r2: busy %b hz %b cnt %0d data %h/%h want 0 0 0 11/11",
               a_b1, a_hz, a_cnt, a_d1, b_d1);
    end
  endtask

  task automatic test_same_edge();
    Reserve = 1'b1; ResReg = 3'd4;
    tick();
    Reserve = 1'b1; ResReg = 3'd4; RegWrite = 1'b1; EscReg = 3'd4; WriteData = 8'h77;
    tick();
    Read1 = 3'd4;
    #1;
    vectors++;
    if (a_b1 !== 1'b1 || a_cnt !== 4'd1 || a_err !== 1'b0 || a_d1 !== 8'h77 ||
        b_err !== 1'b0 || b_d1 !== 8'h77) begin
      miscompares++;
      $display("FAIL same_edge: busy %b cnt %0d err %b/%b data %h/%h want 1 1 0/0 77/77",
               a_b1, a_cnt, a_err, b_err, a_d1, b_d1);
    end
    Reserve = 1'b1; ResReg = 3'd4;
    tick();
    vectors++;
    if (a_err !== 1'b1 || b_err !== 1'b1 || a_cnt !== 4'd1) begin
      miscompares++;
      $display("FAIL double_reserve: err %b/%b cnt %0d want 1/1 1", a_err, b_err, a_cnt);
    end
    RegWrite = 1'b1; EscReg = 3'd4; WriteData = 8'h12;
    tick();
    vectors++;
    if (a_err !== 1'b1 || a_cnt !== 4'd0 || a_d1 !== 8'h12) begin
      miscompares++;
      $display("FAIL err_sticky: err %b cnt %0d data %h want 1 0 12", a_err, a_cnt, a_d1);
    end
  endtask

  task automatic test_reset_priority();
    for (int i = 1; i < 8; i++) begin
      RegWrite = 1'b1; EscReg = 3'(i); WriteData = 8'(8'h10 + i);
      tick();
    end
    Reserve = 1'b1; ResReg = 3'd2;
    tick();
    Reserve = 1'b1; ResReg = 3'd6;
    tick();
    Read1 = 3'd6; Read2 = 3'd7;
    #1;
    vectors++;
    if (a_cnt !== 4'd2 || a_b1 !== 1'b1 || a_d2 !== 8'h17 || a_err !== 1'b1) begin
      miscompares++;
      $display("FAIL pre_reset: cnt %0d busy %b data2 %h err %b want 2 1 17 1",
               a_cnt, a_b1, a_d2, a_err);
    end
    reset = 1'b1; Reserve = 1'b1; ResReg = 3'd3; RegWrite = 1'b1; EscReg = 3'd5;
    WriteData = 8'hEE;
    tick();
    for (int i = 0; i < 8; i++) begin
      Read1 = 3'(i);
      Read2 = 3'(i);
      #1;
      vectors++;
      if ({a_d1, a_d2, b_d1} !== 24'h0 || {a_b1, a_b2, a_hz, a_err, b_err} !== 5'h0 ||
          a_cnt !== 4'd0 || b_cnt !== 4'd0) begin
        miscompares++;
        $display("FAIL reset_priority r%0d: data %h %h %h flags %b%b%b%b%b cnt %0d/%0d want 0",
                 i, a_d1, a_d2, b_d1, a_b1, a_b2, a_hz, a_err, b_err, a_cnt, b_cnt);
      end
    end
  endtask

  initial begin
    #2;
    test_reset();
    test_write_read();
    test_bypass();
    test_reserve_release();
    test_same_edge();
    test_reset_priority();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/reg_file_scoreboard.md
# reg_file_scoreboard

Parametrised register file for the pipelined datapath, with an integrated write-pending scoreboard. Provides two combinational read ports, one clocked write port, a hard-wired zero register, optional write-to-read bypass, and per-register busy bits. Decode uses the busy bits for hazard/stall detection. It sits between decode (read, reserve) and writeback (write, release).

## Interface
- WIDTH, 8, data width in bits
- NREGS, 8, number of registers, power of two ≥ 2; register 0 reads as zero
- BYPASS, 1, 1 = writeback data forwarded to reads in the same cycle; 0 = no forwarding
- AW (localparam), $clog2(NREGS), register index width

Ports:
- clock  in  1  single clock for the whole block; all state updates on rising edge
- reset  in  1  synchronous, active-high
- Read1  in  AW  read port 1 index
- Read2  in  AW  read port 2 index
- Data1  out  WIDTH  read port 1 data (combinational)
- Data2  out  WIDTH  read port 2 data (combinational)
- RegWrite  in  1  writeback enable
- EscReg  in  AW  writeback register index
- WriteData  in  WIDTH  writeback data
- Reserve  in  1  issue-time request to mark a destination pending
- ResReg  in  AW  register to mark pending
- Busy1  out  1  Read1 register has a pending write (combinational)
- Busy2  out  1  Read2 register has a pending write (combinational)
- Hazard  out  1  Busy1 | Busy2
- PendCount  out  AW+1  number of pending registers (registered)
- ResErr  out  1  sticky error: reserve issued to an already-pending register

## Operation
- State: RF[NREGS] of WIDTH bits; pend[NREGS] bits; PendCount; ResErr.
- Reset, sampled on the edge, has priority over all other inputs. It sets every RF entry to 0, every pend bit to 0, PendCount to 0 and ResErr to 0. Reserve and RegWrite on that edge are ignored.
- Write: when RegWrite=1 and EscReg≠0, set RF[EscReg]←WriteData and clear pend[EscReg]. A write to a register that is not pending is legal and raises no error.
- Reserve: when Reserve=1 and ResReg≠0, set pend[ResReg]←1. If pend[ResReg] was already 1 and the same edge does not also write ResReg, set ResErr←1. ResErr stays at 1 until reset.
- Reserve and write to the same register on the same edge: reserve wins. pend stays/becomes 1, RF takes WriteData, ResErr is unaffected.
- Register 0: reads always return 0 and Busy is always 0. Writes and reserves to index 0 are ignored: no count change, no error.
- Read, BYPASS=1: if RegWrite=1, EscReg=ReadN and EscReg≠0, then DataN=WriteData and BusyN=0. Otherwise DataN=RF[ReadN] and BusyN=pend[ReadN].
- Read, BYPASS=0: DataN=RF[ReadN] and BusyN=pend[ReadN] always.
- Reserve is never bypassed. Busy reflects pend state from before the edge.
- PendCount always equals the popcount of pend after the edge. It is updated incrementally: +1 on a 0→1 transition, −1 on a 1→0 transition, unchanged otherwise. Maximum value is NREGS−1.

## Timing
- Write latency: 1 edge, or 0 cycles through the bypass when BYPASS=1.
- Reserve to Busy/Hazard high: visible in the cycle after the edge.
- Writeback to Busy low: same cycle when BYPASS=1 and the register is read; otherwise the cycle after the edge.
- PendCount and ResErr change only on edges.
- All outputs are 0 out of reset: Data1/2 (every RF entry is 0), Busy1/2, Hazard, PendCount, ResErr.
- No handshake; the block accepts one write and one reserve every cycle.

## Test plan
- Reset, then idle reads of r0..r7 → Data=0x00, Busy1=Busy2=Hazard=0, PendCount=0, ResErr=0.
- Write r3←0xA5, then read r3 in the next cycle → Data1=0xA5. Write r0←0xFF → Data1 for r0 reads 0x00, PendCount stays 0.
- BYPASS=1 with r5 pending: RegWrite, EscReg=5, WriteData=0x3C and Read1=5 in the same cycle → Data1=0x3C and Busy1=0 in that cycle. Next cycle PendCount has dropped by 1. Repeat with BYPASS=0 → Data1=old value and Busy1=1 in that cycle.
- Reserve r2 → next cycle Busy1=1 (Read1=2), Hazard=1, PendCount=1. Writeback r2←0x11 → next cycle Busy1=0, Hazard=0, PendCount=0, Data1=0x11.
- With r4 pending, reserve r4 and write r4←0x77 on the same edge → pend[4]=1, PendCount unchanged, ResErr=0, Data=0x77. Then reserve r4 alone → ResErr=1, which stays 1 through later writes.
- Write r1..r7 with nonzero values, reserve r2 and r6, set ResErr, then assert reset with Reserve=1 and ResReg=3 → next cycle all Data=0, Busy=0, PendCount=0, ResErr=0.
